// File: rtl/car_lane.sv
// car_lane: moves N_CARS cars of one road lane across a GRID_W-column field.
// Latency: positions and o_step change one clock after a load or a due tick; o_hit is one clock behind the positions.
// Backpressure: none. i_run=0 parks the lane (HOLD) and freezes both the tick counter and the positions.
// Optional feature macro: CAR_LANE_HIT_EN enables the frog-collision flag. When it is undefined, o_hit is tied to 0.
module car_lane #(
  parameter int N_CARS   = 4,
  parameter int GRID_W   = 20,
  parameter int X_W      = 5,
  parameter int SPACING  = 5,
  parameter int TICK_DIV = 12_500_000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_load,
  input  logic [X_W-1:0]          i_start_x,
  input  logic                    i_dir,
  input  logic [1:0]              i_speed,
  input  logic                    i_run,
  input  logic [X_W-1:0]          i_frog_x,
  input  logic                    i_frog_here,
  output logic [N_CARS*X_W-1:0]   o_car_x,
  output logic                    o_step,
  output logic                    o_hit
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [23:0] TICK_DIV_W = 24'(TICK_DIV);

  logic [1:0]                   state_q, state_d;
  logic [23:0]                  cnt_q, cnt_d;
  logic [N_CARS-1:0][X_W-1:0]   car_x_q, car_x_d;
  logic                         step_q, step_d;
  logic                         hit_q, hit_d;

  logic [23:0] period;
  logic        tick_due;
  logic        step_fire;

  // One column forward or back. X_W+1 bits keep GRID_W-1+1 from aliasing onto 0.
  function automatic logic [X_W-1:0] next_x(input logic [X_W-1:0] x, input logic dir);
    logic [X_W:0] w;
    if (!dir) begin
      w = {1'b0, x} + (X_W+1)'(1);
      if (w >= (X_W+1)'(GRID_W)) begin
        w = '0;
      end
    end else begin
      if (x == '0) begin
        w = (X_W+1)'(GRID_W - 1);
      end else begin
        w = {1'b0, x} - (X_W+1)'(1);
      end
    end
    return w[X_W-1:0];
  endfunction

  // Starting column of car k. An out-of-range i_start_x folds back into the grid.
  function automatic logic [X_W-1:0] load_x(input logic [X_W-1:0] sx, input int k);
    logic [31:0] sum;
    sum = 32'(sx) + 32'(k) * 32'(SPACING);
    return X_W'(sum % 32'(GRID_W));
  endfunction

  // The step period is shifted live from i_speed, so a speed change applies on the very next cycle.
  // Comparing cnt+1 against the period avoids the underflow of period-1 when the period is 0.
  always_comb begin
    period    = TICK_DIV_W >> i_speed;
    tick_due  = ({1'b0, cnt_q} + 25'd1) >= {1'b0, period};
    step_fire = (state_q == ST_RUN) && !i_load && tick_due;
  end

  // Lane mode. A load always lands in RUN; otherwise i_run moves between RUN and HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN:  if (!i_run) state_d = ST_HOLD;
      ST_HOLD: if (i_run)  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (i_load) begin
      state_d = ST_RUN;
    end
  end

  // Tick counter. It counts only while in RUN, is cleared by a load, and rolls over on a step.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick_due) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  // Car positions. Fresh placement wins over a coincident step. i_dir matters only on a step.
  always_comb begin
    car_x_d = car_x_q;
    step_d  = 1'b0;
    if (i_load) begin
      for (int k = 0; k < N_CARS; k++) begin
        car_x_d[k] = load_x(i_start_x, k);
      end
    end else if (step_fire) begin
      step_d = 1'b1;
      for (int k = 0; k < N_CARS; k++) begin
        car_x_d[k] = next_x(car_x_q[k], i_dir);
      end
    end
  end

`ifdef CAR_LANE_HIT_EN
  // Collision check against the current (registered) positions. It is flagged one clock later.
  always_comb begin
    hit_d = 1'b0;
    for (int k = 0; k < N_CARS; k++) begin
      if (car_x_q[k] == i_frog_x) begin
        hit_d = i_frog_here;
      end
    end
  end
`else
  // Collision detection is not built. The frog inputs are deliberately left unused.
  logic unused_frog;
  assign unused_frog = ^{i_frog_x, i_frog_here};
  assign hit_d       = 1'b0;
`endif

  // State registers. An asynchronous reset clears everything immediately.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      car_x_q <= '0;
      step_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      car_x_q <= car_x_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
    end
  end

  assign o_car_x = car_x_q;
  assign o_step  = step_q;
  assign o_hit   = hit_q;

endmodule

// File: tb/tb_car_lane.sv
// Bench for car_lane: directed stimulus, a lane model recomputed from the rules, and a per-cycle compare process.
// The model uses plain integer arithmetic (mod GRID_W, period = TICK_DIV >> speed).
// Literal expectations pin the model at key points.
module tb_car_lane;
  localparam int NC = 4;
  localparam int GW = 20;
  localparam int XW = 5;
  localparam int SP = 5;
  localparam int TD = 8;
`ifdef CAR_LANE_HIT_EN
  localparam bit HIT_ON = 1'b1;
`else
  localparam bit HIT_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic load;
  logic [XW-1:0] start_x;
  logic dir;
  logic [1:0] speed;
  logic run;
  logic [XW-1:0] frog_x;
  logic frog_here;
  logic [NC*XW-1:0] o_car_x;
  logic o_step;
  logic o_hit;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Model state: mode 0 idle, 1 run, 2 hold.
  int m_mode = 0;
  int m_cnt = 0;
  int m_x[NC] = '{default: 0};
  bit m_step = 1'b0;
  bit m_hit = 1'b0;

  car_lane #(.N_CARS(NC), .GRID_W(GW), .X_W(XW), .SPACING(SP), .TICK_DIV(TD)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_load(load), .i_start_x(start_x), .i_dir(dir),
    .i_speed(speed), .i_run(run), .i_frog_x(frog_x), .i_frog_here(frog_here),
    .o_car_x(o_car_x), .o_step(o_step), .o_hit(o_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pk(input int c3, input int c2, input int c1, input int c0);
    return (c3 << 15) | (c2 << 10) | (c1 << 5) | c0;
  endfunction

  // Lane model, advanced on the same events as the design.
  always @(posedge clk or posedge rst) begin
    int period;
    bit hit_now;
    bit do_step;
    if (rst) begin
      m_mode = 0;
      m_cnt = 0;
      for (int k = 0; k < NC; k++) m_x[k] = 0;
      m_step = 1'b0;
      m_hit = 1'b0;
    end else begin
      hit_now = 1'b0;
      for (int k = 0; k < NC; k++) if (frog_here && m_x[k] == int'(frog_x)) hit_now = 1'b1;
      m_hit = HIT_ON && hit_now;
      period = TD >> speed;
      do_step = 1'b0;
      if (load) begin
        for (int k = 0; k < NC; k++) m_x[k] = (int'(start_x) + k * SP) % GW;
        m_cnt = 0;
        m_mode = 1;
      end else begin
        if (m_mode == 1) begin
          if (m_cnt >= period - 1) begin
            do_step = 1'b1;
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
        if (do_step)
          for (int k = 0; k < NC; k++) m_x[k] = dir ? (m_x[k] + GW - 1) % GW : (m_x[k] + 1) % GW;
        if (m_mode == 1 && !run) m_mode = 2;
        else if (m_mode == 2 && run) m_mode = 1;
      end
      m_step = do_step;
    end
  end

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < NC; k++) chk($sformatf("car_x[%0d]", k), int'(o_car_x[k*XW +: XW]), m_x[k]);
      chk("step", int'(o_step), int'(m_step));
      chk("hit", int'(o_hit), int'(m_hit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_step && n < budget);
    chk("step_seen", int'(o_step), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nsteps;
    rst = 1'b1;
    load = 1'b0; start_x = '0; dir = 1'b0; speed = 2'd0; run = 1'b0;
    frog_x = '0; frog_here = 1'b0;
    repeat (3) tick();
    chk("rst_car_x", int'(o_car_x), 0);
    chk("rst_step", int'(o_step), 0);
    chk("rst_hit", int'(o_hit), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_car_x", int'(o_car_x), 0);
    cmp_on = 1'b1;

    // Load at column 0, then move right at speed 0 (period 8).
    start_x = 5'd0; run = 1'b1; dir = 1'b0; speed = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load0", int'(o_car_x), pk(15, 10, 5, 0));
    wait_step(20, n);
    chk("first_interval", n, 8);
    wait_step(20, n);
    chk("interval_s0", n, 8);
    repeat (3) wait_step(20, n);
    chk("wrap_right", int'(o_car_x), pk(0, 15, 10, 5));

    // Reload and move left: car 0 wraps from 0 to 19.
    load = 1'b1; dir = 1'b1;
    tick();
    load = 1'b0;
    wait_step(20, n);
    chk("wrap_left", int'(o_car_x), pk(14, 9, 4, 19));

    // Speed 2 gives period 2.
    speed = 2'd2;
    wait_step(20, n);
    chk("interval_s2", n, 2);
    chk("left_s2", int'(o_car_x), pk(13, 8, 3, 18));

    // Hold for 20 clocks: no steps and no movement.
    run = 1'b0;
    tick();
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_step) nsteps++;
    end
    chk("hold_steps", nsteps, 0);
    chk("hold_pos", int'(o_car_x), pk(13, 8, 3, 18));
    // Resume: the counter kept its value of 1, so the step comes after the HOLD->RUN edge plus one.
    run = 1'b1;
    wait_step(20, n);
    chk("resume_interval", n, 2);
    chk("resume_pos", int'(o_car_x), pk(12, 7, 2, 17));

    // A load on the edge where a step is due wins; start_x 23 folds to 3.
    tick();
    load = 1'b1; start_x = 5'd23; dir = 1'b0;
    tick();
    load = 1'b0;
    chk("load_vs_step", int'(o_step), 0);
    chk("load_mod", int'(o_car_x), pk(18, 13, 8, 3));

    // Frog collision with the lane frozen.
    run = 1'b0; frog_x = 5'd8; frog_here = 1'b1;
    tick();
    tick();
    chk("hit_on", int'(o_hit), int'(HIT_ON));
    frog_here = 1'b0;
    tick();
    chk("hit_off_absent", int'(o_hit), 0);
    frog_x = 5'd9; frog_here = 1'b1;
    tick();
    tick();
    chk("hit_off_miss", int'(o_hit), 0);

    // Asynchronous reset mid-run, with the hit flag raised beforehand.
    frog_x = 5'd3; run = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_car_x", int'(o_car_x), 0);
    chk("arst_step", int'(o_step), 0);
    chk("arst_hit", int'(o_hit), 0);
    tick();
    rst = 1'b0; frog_here = 1'b0;
    repeat (10) tick();
    chk("post_rst_idle", int'(o_car_x), 0);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
